// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader and its byte packer.
// Holds the loader state enum, frame-field widths, word packing size and the default
// largest accepted program length.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;
    localparam int BYTE_W            = 8;
    localparam int LEN_W             = 16;
    localparam int CHK_W             = 8;
    localparam int BYTES_PER_WORD    = 4;
    localparam int DEFAULT_MAX_WORDS = 1024;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory write port of the loader.
// in_valid/in_data/in_ready : byte stream, a byte moves when in_valid && in_ready
// imem_we/imem_addr/imem_wdata : one-cycle instruction word write
// master = stream source / memory side, slave = the loader.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/byte_to_word_packer.sv
// byte_to_word_packer: assembles a big-endian word from a byte stream.
// clk, reset_n : clock, asynchronous active-low reset
// clr          : returns the byte index to the first byte of a word
// byte_i/strobe: incoming byte and its accept strobe
// word         : assembled word, valid together with word_valid
// word_valid   : high in the cycle the last byte of a word is strobed in
module byte_to_word_packer
    import loader_pkg::*;
#(
    parameter int BYTES = BYTES_PER_WORD
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic [BYTE_W-1:0]       byte_i,
    input  logic                    strobe,
    output logic [BYTE_W*BYTES-1:0] word,
    output logic                    word_valid
);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    logic [BYTE_W*(BYTES-1)-1:0] shift_q;
    logic [IDX_W-1:0]            idx_q;
    // The word is presented combinationally so the caller can register it on the
    // same edge that accepts the last byte.
    assign word       = {shift_q, byte_i};
    assign word_valid = strobe && idx_q == IDX_W'(BYTES - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (strobe) begin
            shift_q <= word[BYTE_W*(BYTES-1)-1:0];
            idx_q   <= word_valid ? '0 : idx_q + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed program image from a byte stream into instruction memory.
// clk, reset_n  : clock, asynchronous active-low reset
// start         : one-cycle pulse starting a load (ignored while busy)
// bus           : program_loader_if.slave, byte stream in and imem write port out
// cpu_reset     : processor reset, released the cycle after done rises
// busy/done/error : load in progress / last load good (sticky) / last load bad (sticky)
// words_loaded  : words written by the current or last load
// Optional: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          WORD_W    = 32,
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_reset,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] words_loaded
);
    localparam int CNT_W = ADDR_W + 1;
    state_t                              state_q, state_d;
    logic [BYTE_W-1:0]                   len_hi_q, len_hi_d;
    logic [CNT_W-1:0]                    len_q, len_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0]                   addr_q, addr_d;
    logic [WORD_W-1:0]                   wdata_q, wdata_d;
    logic                                we_q, we_d;
    logic                                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                                cpu_reset_q, cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
    logic [CHK_W-1:0]                    xor_q, xor_d;
`endif
    logic                                ready, acc, len_bad, go;
    logic [LEN_W-1:0]                    len;
    logic [BYTE_W*BYTES_PER_WORD-1:0]    pk_word;
    logic                                pk_valid;
    // No byte is taken during a write cycle, so the word index is settled before the next byte.
    assign ready   = state_q inside {LEN_HI, LEN_LO, DATA, CHK} && !we_q;
    assign acc     = bus.in_valid && ready;
    assign len     = {len_hi_q, bus.in_data};
    assign len_bad = len == '0 || 32'(len) > MAX_WORDS;
    assign go      = start && state_q inside {IDLE, DONE, ERR};
    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (go),
        .byte_i     (bus.in_data),
        .strobe     (acc && state_q == DATA),
        .word       (pk_word),
        .word_valid (pk_valid)
    );
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_reset_d = cpu_reset_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (go) begin
                    state_d     = LEN_HI;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cnt_d       = '0;
                    addr_d      = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d       = '0;
`endif
                end else if (state_q == DONE) begin
                    // done rose on the previous edge; release the processor now.
                    cpu_reset_d = 1'b0;
                end
            end
            LEN_HI: begin
                if (acc) begin
                    len_hi_d = bus.in_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (acc) begin
                    len_d   = CNT_W'(len);
                    state_d = len_bad ? ERR : DATA;
                    error_d = len_bad;
                    busy_d  = !len_bad;
                end
            end
            DATA: begin
                if (pk_valid) begin
                    we_d    = 1'b1;
                    wdata_d = WORD_W'(pk_word);
                    addr_d  = cnt_q[ADDR_W-1:0];
                    cnt_d   = cnt_q + 1'b1;
                end
`ifdef LOADER_CHECKSUM_EN
                xor_d = acc ? xor_q ^ bus.in_data : xor_q;
                if (we_q && cnt_q == len_q) state_d = CHK;
`else
                if (we_q && cnt_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (acc) begin
                    state_d = bus.in_data == xor_q ? DONE : ERR;
                    done_d  = bus.in_data == xor_q;
                    error_d = bus.in_data != xor_q;
                    busy_d  = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_hi_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end
    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader with a frame-level model.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_reset, busy, done, error;
    logic [10:0] words_loaded;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [41:0] exp_q[$];
    logic [31:0] words[$];
    logic        done_prev = 1'b0;

    program_loader_if #(.ADDR_W(10), .WORD_W(32)) bus ();

    program_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Writes must appear in the order the model queued them; the processor reset is
    // released exactly one cycle after done, and no byte is offered during a write.
    always @(negedge clk) begin
        logic [41:0] e;
        chk("cpu_reset_rule", cpu_reset, !(done && done_prev));
        done_prev = done;
        if (bus.imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("imem_addr", bus.imem_addr, e[41:32]);
                chk("imem_wdata", bus.imem_wdata, e[31:0]);
                chk("words_loaded_at_write", words_loaded, 11'(e[41:32]) + 11'd1);
                chk("in_ready_during_write", bus.in_ready, 1'b0);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_imem_we", bus.imem_we, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, 10'd0);
        chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_words_loaded", words_loaded, 11'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Loads the frame described by len and the words queue, then checks the outcome
    // the frame rules predict: good only for 1..1024 words and a matching checksum.
    task automatic do_load(input logic [15:0] len, input bit gaps, input logic [7:0] chk_flip, input int mid_start);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        int         n = 0;
        bit         ok_len = len != 16'd0 && len <= 16'd1024;
        bit         exp_ok = ok_len && chk_flip == 8'h00;
        if (ok_len) foreach (words[i]) exp_q.push_back({10'(i), words[i]});
        pulse_start();
        chk("start_busy", busy, 1'b1);
        chk("start_done", done, 1'b0);
        chk("start_error", error, 1'b0);
        chk("start_words", words_loaded, 11'd0);
        send_byte(len[15:8], gaps);
        send_byte(len[7:0], gaps);
        if (ok_len) begin
            foreach (words[i]) begin
                for (int k = 3; k >= 0; k--) begin
                    b = words[i][8*k +: 8];
                    x ^= b;
                    send_byte(b, gaps);
                    n++;
                    if (n == mid_start) pulse_start();
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(x ^ chk_flip, gaps);
`endif
        end
        n = 0;
        while (!(done || error) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("end_done", done, exp_ok);
        chk("end_error", error, !exp_ok);
        chk("end_busy", busy, 1'b0);
        chk("end_words", words_loaded, ok_len ? 11'(words.size()) : 11'd0);
        chk("end_pending_writes", exp_q.size(), 0);
        if (!exp_ok) begin
            repeat (2) @(negedge clk);
            chk("err_cpu_reset_held", cpu_reset, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("idle_ignores_valid", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;

        // Two-word program, back to back; pins the model with literal values.
        words.delete();
        words.push_back(32'h40000005);
        words.push_back(32'h40000003);
        do_load(16'd2, 1'b0, 8'h00, -1);
        chk("lit_words_loaded", words_loaded, 11'd2);
        chk("lit_cpu_reset_at_done", cpu_reset, 1'b1);
        @(negedge clk);
        chk("lit_cpu_reset_after_done", cpu_reset, 1'b0);
        chk("lit_last_addr", bus.imem_addr, 10'd1);
        chk("lit_last_wdata", bus.imem_wdata, 32'h40000003);

        // Bad lengths: zero and one beyond the limit.
        words.delete();
        do_load(16'h0000, 1'b0, 8'h00, -1);
        do_load(16'h0401, 1'b0, 8'h00, -1);

        // Three words with idle gaps between bytes.
        words.delete();
        words.push_back(32'hDEADBEEF);
        words.push_back(32'h01234567);
        words.push_back(32'hA5C3_0F96);
        do_load(16'd3, 1'b1, 8'h00, -1);

        // Reset after the 6th data byte, then a clean reload.
        exp_q.push_back({10'd0, words[0]});
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(words[i/4][8*(3-i%4) +: 8], 1'b0);
        #2 reset_n = 1'b0;
        #1 check_reset_vals();
        chk("rst_first_word_written", exp_q.size(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_load(16'd3, 1'b0, 8'h00, -1);

        // start while busy is ignored; start from DONE reloads.
        do_load(16'd3, 1'b0, 8'h00, 5);
        do_load(16'd3, 1'b1, 8'h00, -1);

`ifdef LOADER_CHECKSUM_EN
        words.delete();
        words.push_back(32'h12345678);
        do_load(16'd1, 1'b0, 8'h00, -1);
        chk("lit_chk_done", done, 1'b1);
        do_load(16'd1, 1'b0, 8'h01, -1);
        chk("lit_chk_error", error, 1'b1);
        chk("lit_chk_words", words_loaded, 11'd1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
